// File: rtl/rbt_s_ipv6_deparser.sv
`default_nettype none
// ============================================================================
// Module   : rbt_s_ipv6_deparser
// Brief    : Egress deparser stage that prepends a 40-byte IPv6 header to the
//            MSB-aligned protocol header vector (2-stage valid/ready pipe).
// Revision : 1.0 - initial release
// ============================================================================
module rbt_s_ipv6_deparser #(
    parameter int          HEADER_WIDTH       = 2048,
    parameter int          PKT_METADATA_WIDTH = 272,
    parameter logic [7:0]  HOP_LIMIT          = 8'd64,
    parameter logic [7:0]  DEFAULT_NEXT_HDR   = 8'h11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [127:0]                  local_ipv6_addr,
    input  logic                          in_proto_hdr_valid,
    output logic                          in_proto_hdr_ready,
    input  logic [15:0]                   in_proto_hdr_length,
    input  logic [HEADER_WIDTH-1:0]       in_proto_hdr_data,
    input  logic [PKT_METADATA_WIDTH-1:0] in_proto_hdr_pkt_metadata,
    input  logic [15:0]                   in_payload_length,
    output logic                          out_proto_hdr_valid,
    input  logic                          out_proto_hdr_ready,
    output logic [HEADER_WIDTH-1:0]       out_proto_hdr_data,
    output logic [15:0]                   out_proto_hdr_length,
    output logic [PKT_METADATA_WIDTH-1:0] out_proto_hdr_pkt_metadata,
    output logic                          out_proto_hdr_error,
    output logic [31:0]                   stat_built_count,
    output logic [31:0]                   stat_bypass_count,
    output logic [15:0]                   stat_error_count
);

    localparam int          IP6_HDR_BITS = 320;
    localparam logic [15:0] IP6_HDR_LEN  = 16'd40;
    localparam logic [8:0]  IP6_HDR_OFS  = 9'd40;
    localparam logic [15:0] MAX_IN_LEN   = 16'(HEADER_WIDTH / 8 - 40);
    localparam int          TAG_IPV6_BIT = 44;
    localparam int          TAG_IDP_BIT  = 45;
    localparam int          DST_IP_LSB   = 104;
    localparam int          SEATL_LSB    = 252;
    localparam logic [7:0]  IDP_NEXT_HDR = 8'h92;

    // Handshake / stage advance
    logic s2_adv;
    logic s1_adv;
    logic in_fire;

    // Stage 1 registers
    logic                          s1_valid_q,       s1_valid_d;
    logic [HEADER_WIDTH-1:0]       s1_data_q,        s1_data_d;
    logic [15:0]                   s1_length_q,      s1_length_d;
    logic [PKT_METADATA_WIDTH-1:0] s1_meta_q,        s1_meta_d;
    logic [15:0]                   s1_payload_len_q, s1_payload_len_d;
    logic [127:0]                  s1_src_addr_q,    s1_src_addr_d;
    logic                          s1_build_q,       s1_build_d;
    logic [7:0]                    s1_next_hdr_q,    s1_next_hdr_d;
    logic                          s1_error_q,       s1_error_d;
    logic                          s1_underflow_q,   s1_underflow_d;
    logic [19:0]                   s1_flow_q,        s1_flow_d;

    // Stage 2 (output) registers
    logic                          s2_valid_q,  s2_valid_d;
    logic [HEADER_WIDTH-1:0]       s2_data_q,   s2_data_d;
    logic [15:0]                   s2_length_q, s2_length_d;
    logic [PKT_METADATA_WIDTH-1:0] s2_meta_q,   s2_meta_d;
    logic                          s2_error_q,  s2_error_d;

    // Flow label and statistics
    logic [19:0] flow_label_q,  flow_label_d;
    logic [31:0] built_cnt_q,   built_cnt_d;
    logic [31:0] bypass_cnt_q,  bypass_cnt_d;
    logic [15:0] error_cnt_q,   error_cnt_d;

    // Input-side decode
    logic       in_build;
    logic       in_idp;
    logic [8:0] in_seatl;
    logic       in_overflow;
    logic       in_underflow;

    // Stage-2 assembly
    logic [IP6_HDR_BITS-1:0]       ip6_hdr;
    logic [HEADER_WIDTH-1:0]       built_data;
    logic [PKT_METADATA_WIDTH-1:0] built_meta;
    logic [8:0]                    s1_seatl;

    always_comb begin
        s2_adv             = !s2_valid_q || out_proto_hdr_ready;
        s1_adv             = !s1_valid_q || s2_adv;
        in_proto_hdr_ready = s1_adv;
        in_fire            = in_proto_hdr_valid && s1_adv;
    end

    always_comb begin
        in_build     = in_proto_hdr_pkt_metadata[TAG_IPV6_BIT];
        in_idp       = in_proto_hdr_pkt_metadata[TAG_IDP_BIT];
        in_seatl     = in_proto_hdr_pkt_metadata[SEATL_LSB +: 9];
        in_overflow  = in_proto_hdr_length > MAX_IN_LEN;
        in_underflow = in_seatl < IP6_HDR_OFS;
    end

    // Stage 1: capture the beat and resolve everything that depends on tags.
    always_comb begin
        s1_valid_d       = s1_valid_q;
        s1_data_d        = s1_data_q;
        s1_length_d      = s1_length_q;
        s1_meta_d        = s1_meta_q;
        s1_payload_len_d = s1_payload_len_q;
        s1_src_addr_d    = s1_src_addr_q;
        s1_build_d       = s1_build_q;
        s1_next_hdr_d    = s1_next_hdr_q;
        s1_error_d       = s1_error_q;
        s1_underflow_d   = s1_underflow_q;
        s1_flow_d        = s1_flow_q;
        if (s1_adv) begin
            s1_valid_d = in_proto_hdr_valid;
        end
        if (in_fire) begin
            s1_data_d        = in_proto_hdr_data;
            s1_length_d      = in_proto_hdr_length;
            s1_meta_d        = in_proto_hdr_pkt_metadata;
            s1_payload_len_d = in_payload_length;
            s1_src_addr_d    = local_ipv6_addr;
            s1_build_d       = in_build;
            s1_next_hdr_d    = in_idp ? IDP_NEXT_HDR : DEFAULT_NEXT_HDR;
            s1_error_d       = in_build && (in_overflow || in_underflow);
            s1_underflow_d   = in_build && in_underflow;
            s1_flow_d        = flow_label_q;
        end
    end

    always_comb begin
        s1_seatl = s1_meta_q[SEATL_LSB +: 9];
        ip6_hdr  = {4'h6, 8'h00, s1_flow_q, s1_payload_len_q, s1_next_hdr_q,
                    HOP_LIMIT, s1_src_addr_q, s1_meta_q[DST_IP_LSB +: 128]};
        built_data = {ip6_hdr, s1_data_q[HEADER_WIDTH-1:IP6_HDR_BITS]};
        built_meta = s1_meta_q;
        // Clearing the tag stops any later deparser from prepending again.
        built_meta[TAG_IPV6_BIT]    = 1'b0;
        built_meta[SEATL_LSB +: 9]  = s1_underflow_q ? 9'd0 : (s1_seatl - IP6_HDR_OFS);
    end

    // Stage 2: output registers only reload when the consumer can take a beat.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_data_d   = s2_data_q;
        s2_length_d = s2_length_q;
        s2_meta_d   = s2_meta_q;
        s2_error_d  = s2_error_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                if (s1_build_q) begin
                    s2_data_d   = built_data;
                    s2_length_d = s1_length_q + IP6_HDR_LEN;
                    s2_meta_d   = built_meta;
                    s2_error_d  = s1_error_q;
                end else begin
                    s2_data_d   = s1_data_q;
                    s2_length_d = s1_length_q;
                    s2_meta_d   = s1_meta_q;
                    s2_error_d  = 1'b0;
                end
            end
        end
    end

    always_comb begin
        flow_label_d = flow_label_q;
        built_cnt_d  = built_cnt_q;
        bypass_cnt_d = bypass_cnt_q;
        error_cnt_d  = error_cnt_q;
        if (in_fire) begin
            if (in_build) begin
                flow_label_d = flow_label_q + 20'd1;
                built_cnt_d  = built_cnt_q + 32'd1;
                if ((in_overflow || in_underflow) && (error_cnt_q != 16'hFFFF)) begin
                    error_cnt_d = error_cnt_q + 16'd1;
                end
            end else begin
                bypass_cnt_d = bypass_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q       <= 1'b0;
            s1_data_q        <= '0;
            s1_length_q      <= '0;
            s1_meta_q        <= '0;
            s1_payload_len_q <= '0;
            s1_src_addr_q    <= '0;
            s1_build_q       <= 1'b0;
            s1_next_hdr_q    <= '0;
            s1_error_q       <= 1'b0;
            s1_underflow_q   <= 1'b0;
            s1_flow_q        <= '0;
            s2_valid_q       <= 1'b0;
            s2_data_q        <= '0;
            s2_length_q      <= '0;
            s2_meta_q        <= '0;
            s2_error_q       <= 1'b0;
            flow_label_q     <= '0;
            built_cnt_q      <= '0;
            bypass_cnt_q     <= '0;
            error_cnt_q      <= '0;
        end else begin
            s1_valid_q       <= s1_valid_d;
            s1_data_q        <= s1_data_d;
            s1_length_q      <= s1_length_d;
            s1_meta_q        <= s1_meta_d;
            s1_payload_len_q <= s1_payload_len_d;
            s1_src_addr_q    <= s1_src_addr_d;
            s1_build_q       <= s1_build_d;
            s1_next_hdr_q    <= s1_next_hdr_d;
            s1_error_q       <= s1_error_d;
            s1_underflow_q   <= s1_underflow_d;
            s1_flow_q        <= s1_flow_d;
            s2_valid_q       <= s2_valid_d;
            s2_data_q        <= s2_data_d;
            s2_length_q      <= s2_length_d;
            s2_meta_q        <= s2_meta_d;
            s2_error_q       <= s2_error_d;
            flow_label_q     <= flow_label_d;
            built_cnt_q      <= built_cnt_d;
            bypass_cnt_q     <= bypass_cnt_d;
            error_cnt_q      <= error_cnt_d;
        end
    end

    always_comb begin
        out_proto_hdr_valid        = s2_valid_q;
        out_proto_hdr_data         = s2_data_q;
        out_proto_hdr_length       = s2_length_q;
        out_proto_hdr_pkt_metadata = s2_meta_q;
        out_proto_hdr_error        = s2_error_q;
        stat_built_count           = built_cnt_q;
        stat_bypass_count          = bypass_cnt_q;
        stat_error_count           = error_cnt_q;
    end

endmodule
`default_nettype wire

// File: doc/rbt_s_ipv6_deparser.md
# rbt_s_ipv6_deparser

Transmit-side counterpart of the IPv6 parser stage. It prepends a 40-byte IPv6 header to the MSB-aligned protocol header vector, built from packet metadata plus local configuration. It shifts the existing header content down by 320 bits, grows the length by 40, and rewinds the SEATL offset. It sits in the egress deparser chain, upstream of header/payload merge, and runs as a 2-stage valid/ready pipeline at full throughput.

## Interface
- HEADER_WIDTH, 2048: header vector width in bits; multiple of 8 and ≥ 640.
- PKT_METADATA_WIDTH, 272: metadata width.
- HOP_LIMIT, 8'd64: hop limit written into every built header.
- DEFAULT_NEXT_HDR, 8'h11: next-header value when the IDP tag is clear.
- Reset: rst, synchronous, active-high. Clock: clk.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- local_ipv6_addr  in  128  source address; sampled at stage-1 acceptance
- in_proto_hdr_valid / in_proto_hdr_ready  in / out  1 / 1  input handshake
- in_proto_hdr_length  in  16  valid bytes in in_proto_hdr_data
- in_proto_hdr_data  in  HEADER_WIDTH  header bytes, MSB-aligned (first byte at [HEADER_WIDTH-1 -: 8])
- in_proto_hdr_pkt_metadata  in  PKT_METADATA_WIDTH  metadata
- in_payload_length  in  16  IPv6 payload length field value in bytes
- out_proto_hdr_valid / out_proto_hdr_ready  out / in  1 / 1  output handshake
- out_proto_hdr_data  out  HEADER_WIDTH  resulting header vector
- out_proto_hdr_length  out  16  resulting byte length
- out_proto_hdr_pkt_metadata  out  PKT_METADATA_WIDTH  updated metadata
- out_proto_hdr_error  out  1  overflow or offset-underflow flag for this beat
- stat_built_count  out  32  headers built
- stat_bypass_count  out  32  beats passed through
- stat_error_count  out  16  beats with the error flag set

## Operation
- Metadata fields (bit offsets):
  - PROTO [40 +: 32]; IPv6 tag is PROTO bit 4, IDP tag is PROTO bit 5.
  - DST_IP [104 +: 128].
  - SEATL_OFFSET [252 +: 9].
- Build path (IPv6 tag set):
  - Header H (320 bits, MSB first) = {4'h6, 8'h00 traffic class, flow_label[19:0], in_payload_length, next_hdr, HOP_LIMIT, local_ipv6_addr, DST_IP}.
  - next_hdr = 8'h92 if the IDP tag is set, else DEFAULT_NEXT_HDR.
  - out_data = {H, in_data[HEADER_WIDTH-1 : 320]}; the low 320 input bits are discarded.
  - out_length = in_length + 40.
  - SEATL_OFFSET_out = SEATL_OFFSET_in − 40. All other metadata bits pass unchanged.
  - The IPv6 tag is cleared in the output metadata, so a downstream deparser does not rebuild the header.
- Bypass path (IPv6 tag clear): data, length and metadata pass unchanged; error = 0; flow label is not consumed.
- Error conditions, build path only:
  - Overflow: in_length > HEADER_WIDTH/8 − 40 (216 at default). The beat is still emitted as built and error = 1.
  - Offset underflow: SEATL_OFFSET_in < 40. SEATL_OFFSET_out = 0 (saturated), error = 1.
  - Both conditions together give a single error = 1 and a single stat_error_count increment.
- Flow label: 20-bit counter, reset 0. Each built beat uses the current value; the counter increments when that beat is accepted into stage 1. It wraps 20'hFFFFF → 0.
- Counters:
  - Increment when a beat is accepted into stage 1.
  - stat_built_count and stat_bypass_count wrap at 2^32.
  - stat_error_count saturates at 16'hFFFF.

## Timing
- Stage 1 registers the inputs and decodes the tags, next_hdr, error and flow label.
- Stage 2 registers the assembled data, length and metadata, which drive the outputs.
- Latency: 2 cycles from input acceptance to out_proto_hdr_valid.
- Throughput: 1 beat per cycle when out_proto_hdr_ready stays high.
- Stage advance rules:
  - s2_adv = !s2_valid | out_proto_hdr_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_proto_hdr_ready = s1_adv (combinational from out_proto_hdr_ready, no skid buffer).
- Output data, length, metadata and error are held stable while out_proto_hdr_valid=1 and out_proto_hdr_ready=0.
- Reset clears:
  - both stage valids and all output registers, so every output reads 0 and in_proto_hdr_ready = 1 after reset;
  - the flow label and all stat counters.
- Reset mid-transfer discards in-flight beats with no output.
- Simultaneous events: when input and output handshakes fire in the same cycle, both stages advance and no bubble is inserted.

## Test plan
- Build beat: IPv6 tag=1, IDP=0, length 60, SEATL_OFFSET 100, DST_IP=2001:db8::1, payload 20 -> after 2 cycles:
  - data[2047:2044]=4'h6, next_hdr 8'h11, hop limit 64;
  - bytes 40..99 equal input bytes 0..59;
  - length 100, SEATL_OFFSET 60, IPv6 tag 0, error 0.
- IDP beat: IDP=1 -> next_hdr byte (out byte 6) = 8'h92; flow label increments by 1 over the previous beat.
- Bypass: IPv6 tag=0 -> data, length and metadata pass bit-exact; stat_bypass_count +1; flow label unchanged.
- Errors:
  - length 220 -> error=1, out_length 260;
  - SEATL_OFFSET 10 -> SEATL_OFFSET_out=0, error=1;
  - stat_error_count counts 2.
- Backpressure: 10 back-to-back beats with out_proto_hdr_ready toggled randomly -> all 10 emitted in order, none lost or duplicated, outputs stable while stalled; with ready held at 1, throughput is 1 per cycle.
- Wrap and reset:
  - flow label preloaded at 20'hFFFFF via 2^20−1 built beats (or forced) -> next value 0;
  - rst asserted with 2 beats in flight -> outputs 0, no beats emitted, counters 0.
